// File: rtl/alu_sequencer_if.sv
// ALU op encoding and the instruction handshake bundle
// shared by the decoder (master) and alu_sequencer (slave).
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_op_e;
endpackage

interface alu_sequencer_if #(
    parameter int RW = 2
);
    import alu_pkg::*;

    logic          instr_valid;
    logic          instr_ready;
    alu_op_e       instr_op;
    logic [RW-1:0] instr_src_a;
    logic [RW-1:0] instr_src_b;
    logic [RW-1:0] instr_dst;
    logic          instr_cmp;

    modport master (
        output instr_valid, instr_op,
        output instr_src_a, instr_src_b,
        output instr_dst, instr_cmp,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op,
        input  instr_src_a, instr_src_b,
        input  instr_dst, instr_cmp,
        output instr_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer driving a combinational ALU from a register file.
// Define ALU_SEQ_COMPARE_EN to let instr_cmp suppress the writeback.
module alu_sequencer
  import alu_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int REG_COUNT      = 4,
    localparam int RW = $clog2(REG_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_sequencer_if.slave            instr,
    input  logic                      ext_we,
    input  logic [RW-1:0]             ext_idx,
    input  logic [DATA_BUS_WIDTH-1:0] ext_data,
    output logic [DATA_BUS_WIDTH-1:0] ext_rd_data,
    output alu_op_e                   alu_op,
    output logic [DATA_BUS_WIDTH-1:0] alu_register1,
    output logic [DATA_BUS_WIDTH-1:0] alu_register2,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  logic                      alu_is_carry,
    input  logic                      alu_is_zero,
    output logic                      flag_carry,
    output logic                      flag_zero,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        WB
    } state_e;

    state_e                    state;
    logic [DATA_BUS_WIDTH-1:0] rf [REG_COUNT];
    alu_op_e                   op_q;
    logic [RW-1:0]             src_a_q;
    logic [RW-1:0]             src_b_q;
    logic [RW-1:0]             dst_q;
    logic                      cmp_q;
    logic [DATA_BUS_WIDTH-1:0] res_q;
    logic                      carry_q;
    logic                      zero_q;
    logic                      cmp_in;

`ifdef ALU_SEQ_COMPARE_EN
    assign cmp_in = instr.instr_cmp;
`else
    logic unused_cmp;
    assign cmp_in     = 1'b0;
    assign unused_cmp = instr.instr_cmp;
`endif

    assign instr.instr_ready = (state == IDLE);
    assign ext_rd_data       = rf[ext_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            for (int i = 0; i < REG_COUNT; i++)
                rf[i] <= '0;
            op_q          <= alu_op_e'(0);
            src_a_q       <= '0;
            src_b_q       <= '0;
            dst_q         <= '0;
            cmp_q         <= 1'b0;
            res_q         <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            alu_op        <= alu_op_e'(0);
            alu_register1 <= '0;
            alu_register2 <= '0;
            flag_carry    <= 1'b0;
            flag_zero     <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // a write on the handshake edge is seen by FETCH
                    if (ext_we)
                        rf[ext_idx] <= ext_data;
                    if (instr.instr_valid) begin
                        op_q    <= instr.instr_op;
                        src_a_q <= instr.instr_src_a;
                        src_b_q <= instr.instr_src_b;
                        dst_q   <= instr.instr_dst;
                        cmp_q   <= cmp_in;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    alu_op        <= op_q;
                    alu_register1 <= rf[src_a_q];
                    alu_register2 <= rf[src_b_q];
                    state         <= EXEC;
                end
                EXEC: begin
                    res_q   <= alu_result;
                    carry_q <= alu_is_carry;
                    zero_q  <= alu_is_zero;
                    state   <= WB;
                end
                WB: begin
                    if (!cmp_q)
                        rf[dst_q] <= res_q;
                    flag_carry <= carry_q;
                    flag_zero  <= zero_q;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execution sequencer that is the initiating side of the ALU interface. It accepts one register-to-register instruction per handshake, reads operands from its internal register file and drives `op`/`register1`/`register2` into the ALU. It then captures `result`/`is_carry`/`is_zero`, writes the result back and holds the architectural carry/zero flags. It sits between the instruction decoder (upstream valid/ready) and the combinational `alu` (downstream).

## Interface
- `DATA_BUS_WIDTH`, 8, width of registers and ALU operands
- `REG_COUNT`, 4, number of general registers; index width `RW = $clog2(REG_COUNT)`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  sequencer can accept
- `instr_op`  in  `alu_op_e`  ALU operation
- `instr_src_a`, `instr_src_b`, `instr_dst`  in  RW  register indices
- `instr_cmp`  in  1  compare: flags only, no writeback (see Configuration)
- `ext_we`  in  1  external register write strobe
- `ext_idx`  in  RW  external write/read index
- `ext_data`  in  DATA_BUS_WIDTH  external write data
- `ext_rd_data`  out  DATA_BUS_WIDTH  combinational `rf[ext_idx]`
- `alu_op`  out  `alu_op_e`  to ALU `op`
- `alu_register1`, `alu_register2`  out  DATA_BUS_WIDTH  to ALU operands
- `alu_result`  in  DATA_BUS_WIDTH  from ALU `result`
- `alu_is_carry`, `alu_is_zero`  in  1  from ALU flags
- `flag_carry`, `flag_zero`  out  1  architectural flags
- `done`  out  1  one-cycle pulse on instruction retirement

## Operation
- FSM states: IDLE, FETCH, EXEC, WB. `instr_ready = (state == IDLE)`.
- IDLE: on `instr_valid && instr_ready` latch op, indices and cmp, then go to FETCH. Otherwise stay in IDLE.
- FETCH: load `alu_op`, `alu_register1 = rf[src_a]` and `alu_register2 = rf[src_b]` into output registers, then go to EXEC.
- EXEC: ALU outputs settle. Capture `alu_result`, `alu_is_carry` and `alu_is_zero` into internal holding registers, then go to WB.
- WB: write the held result to `rf[dst]` unless the write is suppressed by cmp. Update `flag_carry`/`flag_zero` from the held values. Assert `done` (registered), then go to IDLE.
- ALU outputs hold their last values in IDLE. They change only in FETCH.
- External writes:
  - Honoured only when state is IDLE.
  - If an external write lands on the same edge as a handshake, the write takes effect and the FETCH of that instruction sees the new value.
  - `ext_we` in any other state is ignored, with no error.
- `dst` equal to `src_a`/`src_b` is legal. Operands are read in FETCH, before the WB write.
- All register file entries are DATA_BUS_WIDTH bits. No width extension. Carry comes from the ALU only.

## Timing
- Handshake at edge E0. Operand and op registers update at E1. The result is captured at E2. RF and flags update at E3, and `done` is high during the cycle after E3.
- `instr_ready` rises in the cycle after E3. Throughput is one instruction per 4 cycles.
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - All `rf` entries, `alu_register1`, `alu_register2`, the holding registers, `flag_carry`, `flag_zero` and `done` are cleared to 0.
  - `alu_op` is cleared to enum value 0.
  - `instr_ready` is 1 after reset releases.
  - An instruction in flight is dropped, with no writeback and no `done`.
- `instr_valid` while not ready is ignored. Upstream holds it until ready.

## Configuration
- `ALU_SEQ_COMPARE_EN` defined:
  - `instr_cmp` is latched at handshake.
  - When it is 1, WB skips the RF write and still updates the flags and pulses `done`.
- Not defined:
  - `instr_cmp` is ignored (unconnected internally).
  - Every instruction writes back.

## Test plan
- Reset mid-EXEC after loading rf[0]=0x05 -> all registers and flags are 0, `done` never pulses, `instr_ready`=1 the cycle after release.
- ext writes rf[0]=0x0F, rf[1]=0x01; add, a=0, b=1, dst=2 -> `done` three cycles after handshake cycle, `ext_rd_data`(idx 2)=0x10, carry=0, zero=0.
- rf[0]=0xFF, rf[1]=0x01; add, dst=3 -> rf[3]=0x00, `flag_carry`=1, `flag_zero`=1.
- rf[0]=0x22; sub, a=0, b=0, dst=0 -> rf[0]=0x00 and zero=1. A second back-to-back instruction is accepted exactly 4 cycles after the first handshake.
- `ext_we` to rf[1]=0xAA while in EXEC -> rf[1] is unchanged. The same `ext_we` coincident with a handshake reading rf[1] -> the ALU sees 0xAA.
- With `ALU_SEQ_COMPARE_EN`, sub with cmp=1 on rf[0]=rf[1]=0x33, dst=0 -> rf[0] stays 0x33, zero=1, `done` pulses. Without the macro, rf[0] becomes 0x00.
